toggle_decoder: RTL

TOGGLE_DECODER -- requirements
Module: toggle_decoder

---
 rtl/toggle_decoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/toggle_decoder.sv
// Toggle-encoded event decoder: every level change on t_in becomes one pulse, with count/sat/ovr status.
// Define TOGGLE_DECODER_SYNC_EN to put a two-flop synchronizer on t_in (asynchronous input); default is one sample flop.
module toggle_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t_in,
    input  logic             enable,
    input  logic             clr,
    input  logic             ack,
    output logic             pulse,
    output logic             pending,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             ovr,
    output logic             q
);

    // state | meaning
    // INIT  | after reset, input pipeline and prev absorb the t_in level; pulses suppressed
    // IDLE  | no event awaiting acknowledge
    // PEND  | decoded event awaiting ack
    typedef enum logic [1:0] {INIT, IDLE, PEND} state_t;

`ifdef TOGGLE_DECODER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    // INIT lasts until prev holds the level sampled at release, so a high t_in never shows as an edge
    localparam logic [1:0] INIT_LEN = 2'(D);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [D-1:0]     sync_q, sync_d;
    logic             prev_q, prev_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             ovr_q, ovr_d;
    logic [1:0]       init_q, init_d;
    state_t           state_q, state_d;
    logic             s_last;

    assign s_last = sync_q[D-1];

    always_comb begin
`ifdef TOGGLE_DECODER_SYNC_EN
        sync_d  = {sync_q[0], t_in};
`else
        sync_d  = t_in;
`endif
        prev_d  = s_last;
        pulse_d = enable & (s_last ^ prev_q) & (state_q != INIT);
        init_d  = init_q;
        state_d = state_q;
        count_d = count_q;
        sat_d   = sat_q;
        ovr_d   = ovr_q;

        case (state_q)
            INIT: begin
                if (init_q == 2'd0) state_d = IDLE;
                else                init_d  = init_q - 2'd1;
            end
            IDLE: if (pulse_d) state_d = PEND;
            PEND: begin
                if (ack && !pulse_d) state_d = IDLE;
                if (pulse_d && !ack) ovr_d = 1'b1;
            end
            default: state_d = INIT;
        endcase

        if (pulse_d && count_q != CNT_MAX) count_d = count_q + 1'b1;
        if (count_d == CNT_MAX) sat_d = 1'b1;

        // clr wins over a same-cycle event for status, but the pulse itself still goes out
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
            ovr_d   = 1'b0;
            if (state_q != INIT) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
            init_q  <= INIT_LEN;
            state_q <= INIT;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
            init_q  <= init_d;
            state_q <= state_d;
        end
    end

    assign pulse   = pulse_q;
    assign pending = (state_q == PEND);
    assign count   = count_q;
    assign sat     = sat_q;
    assign ovr     = ovr_q;
    assign q       = prev_q;

endmodule
